// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank
// Bank of hardware performance counters with per-counter event select,
// inhibit, sticky overflow and overflow interrupt enable. Counters are
// reached through a 32-bit CSR port. A high-half shadow makes a low/high
// split read of a counter coherent.
module hpm_counter_bank #(
  parameter int NUM_COUNTERS = 4,
  parameter int WIDTH        = 64,
  parameter int NUM_EVENTS   = 8,
  localparam int SEL_W       = $clog2(NUM_EVENTS + 2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_EVENTS-1:0]   events,
  input  logic                    freeze,
  input  logic [3:0]              csr_idx,
  input  logic [1:0]              csr_field,
  input  logic                    csr_re,
  input  logic                    csr_we,
  input  logic [31:0]             csr_wd,
  output logic [31:0]             csr_rd,
  output logic [NUM_COUNTERS-1:0] ovf,
  output logic                    irq
);

  localparam int HI_W  = WIDTH - 32;
  // Event source table padded to a power of two so that any sel value
  // indexes safely; padding entries are zero and therefore never count.
  localparam int EXT_W = 1 << SEL_W;

  logic [WIDTH-1:0]        count_r [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_r   [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] inh_r;
  logic [NUM_COUNTERS-1:0] ie_r;
  logic [NUM_COUNTERS-1:0] ovf_r;
  logic [HI_W-1:0]         shadow_r;
  logic [3:0]              shadow_idx_r;
  logic                    shadow_vld_r;

  logic [EXT_W-1:0]        ev_ext_s;
  logic [NUM_COUNTERS-1:0] lo_wr_s;
  logic [NUM_COUNTERS-1:0] hi_wr_s;
  logic [NUM_COUNTERS-1:0] sel_wr_s;
  logic [NUM_COUNTERS-1:0] ctl_wr_s;
  logic [NUM_COUNTERS-1:0] inc_s;
  logic [NUM_COUNTERS-1:0] wrap_s;
  logic                    idx_ok_s;
  logic [WIDTH-1:0]        cur_cnt_s;
  logic [SEL_W-1:0]        cur_sel_s;
  logic [2:0]              cur_ctl_s;
  logic [31:0]             rd_s;
  logic [31:0]             hi_ext_s;
  logic [31:0]             shadow_ext_s;
  logic [31:0]             sel_ext_s;

  // Event source vector: entry 0 is the always-on cycle source, entry k is events[k-1].
  always_comb begin
    ev_ext_s                 = '0;
    ev_ext_s[NUM_EVENTS:0]   = {events, 1'b1};
  end

  // Per-counter write decode, increment qualification and wrap detection.
  always_comb begin
    lo_wr_s  = '0;
    hi_wr_s  = '0;
    sel_wr_s = '0;
    ctl_wr_s = '0;
    inc_s    = '0;
    wrap_s   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_we && (csr_idx == 4'(i))) begin
        lo_wr_s[i]  = (csr_field == 2'b00);
        hi_wr_s[i]  = (csr_field == 2'b01);
        sel_wr_s[i] = (csr_field == 2'b10);
        ctl_wr_s[i] = (csr_field == 2'b11);
      end else begin
        lo_wr_s[i]  = 1'b0;
        hi_wr_s[i]  = 1'b0;
        sel_wr_s[i] = 1'b0;
        ctl_wr_s[i] = 1'b0;
      end
      // A software load of either half takes precedence over counting.
      inc_s[i]  = ev_ext_s[sel_r[i]] && !inh_r[i] && !freeze && !lo_wr_s[i] && !hi_wr_s[i];
      wrap_s[i] = inc_s[i] && (&count_r[i]);
    end
  end

  // Select the addressed counter's state; out-of-range indices match nothing.
  always_comb begin
    idx_ok_s  = 1'b0;
    cur_cnt_s = '0;
    cur_sel_s = '0;
    cur_ctl_s = 3'b000;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_idx == 4'(i)) begin
        idx_ok_s  = 1'b1;
        cur_cnt_s = count_r[i];
        cur_sel_s = sel_r[i];
        cur_ctl_s = {ovf_r[i], ie_r[i], inh_r[i]};
      end else begin
        idx_ok_s  = idx_ok_s;
      end
    end
  end

  // CSR read mux built from pre-edge register values, zero-extended to 32 bits.
  always_comb begin
    hi_ext_s                 = 32'b0;
    hi_ext_s[HI_W-1:0]       = cur_cnt_s[WIDTH-1:32];
    shadow_ext_s             = 32'b0;
    shadow_ext_s[HI_W-1:0]   = shadow_r;
    sel_ext_s                = 32'b0;
    sel_ext_s[SEL_W-1:0]     = cur_sel_s;
    rd_s                     = 32'b0;
    if (idx_ok_s) begin
      case (csr_field)
        2'b00: rd_s = cur_cnt_s[31:0];
        2'b01: begin
          if (shadow_vld_r && (shadow_idx_r == csr_idx)) begin
            rd_s = shadow_ext_s;
          end else begin
            rd_s = hi_ext_s;
          end
        end
        2'b10: rd_s = sel_ext_s;
        2'b11: rd_s = {29'b0, cur_ctl_s};
        default: rd_s = 32'b0;
      endcase
    end else begin
      rd_s = 32'b0;
    end
  end

  // Counter, selector, control and sticky overflow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        count_r[i] <= '0;
        sel_r[i]   <= '0;
      end
      inh_r <= '0;
      ie_r  <= '0;
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (lo_wr_s[i]) begin
          count_r[i][31:0] <= csr_wd;
        end else if (hi_wr_s[i]) begin
          count_r[i][WIDTH-1:32] <= csr_wd[HI_W-1:0];
        end else if (inc_s[i]) begin
          count_r[i] <= count_r[i] + WIDTH'(1);
        end
        if (sel_wr_s[i]) begin
          sel_r[i] <= csr_wd[SEL_W-1:0];
        end
        if (ctl_wr_s[i]) begin
          inh_r[i] <= csr_wd[0];
          ie_r[i]  <= csr_wd[1];
        end
        // A wrap on the same edge beats a write-1-clear.
        if (wrap_s[i]) begin
          ovf_r[i] <= 1'b1;
        end else if (ctl_wr_s[i] && csr_wd[2]) begin
          ovf_r[i] <= 1'b0;
        end
      end
    end
  end

  // High-half shadow: captured by a low-half read, dropped by any write to its counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_r     <= '0;
      shadow_idx_r <= 4'd0;
      shadow_vld_r <= 1'b0;
    end else if (idx_ok_s && csr_re && (csr_field == 2'b00)) begin
      shadow_r     <= cur_cnt_s[WIDTH-1:32];
      shadow_idx_r <= csr_idx;
      shadow_vld_r <= !csr_we;
    end else if (idx_ok_s && csr_we && (csr_idx == shadow_idx_r)) begin
      shadow_vld_r <= 1'b0;
    end
  end

  assign csr_rd = rd_s;
  assign ovf    = ovf_r;
  assign irq    = |(ovf_r & ie_r);

endmodule
